vend_controller: RTL and testbench

//  Top-level sequencer for the vending datapath. Accumulates coin credit, accepts
//  a product selection, runs a dispense handshake with the motor driver, and

---
 rtl/vend_pkg.sv | 23 ++
 rtl/timeout_counter.sv | 27 ++
 rtl/vend_controller.sv | 165 ++++++++++++++++
 tb/tb_vend_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, legal coin values, change coin codes.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISPENSE,
    ST_CHANGE,
    ST_FAULT
  } state_t;

  localparam logic [4:0] COIN_1  = 5'd1;
  localparam logic [4:0] COIN_5  = 5'd5;
  localparam logic [4:0] COIN_10 = 5'd10;

  localparam logic CHG_COIN_1 = 1'b0;
  localparam logic CHG_COIN_5 = 1'b1;

  function automatic logic coin_legal(input logic [4:0] v);
    return (v == COIN_1) || (v == COIN_5) || (v == COIN_10);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Counts enabled cycles since the last clear; expired is high on the LIMIT-th enabled cycle.
// Combinational expired flag, saturates at LIMIT-1 so it never wraps.
module timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, product selection, dispense handshake, 5/1 change return.
// All outputs registered one cycle after the triggering strobe; change waits on chg_ready.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE0       = 20,
  parameter int PRICE1       = 15,
  parameter int PRICE2       = 10,
  parameter int PRICE3       = 5,
  parameter int MAX_CREDIT   = 29,
  parameter int IDLE_TIMEOUT = 50000000,
  parameter int DISP_TIMEOUT = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [4:0] coin_value,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  input  logic       disp_done,
  input  logic       chg_ready,
  output logic [4:0] credit,
  output logic       coin_reject,
  output logic       sel_nack,
  output logic       disp_req,
  output logic [1:0] disp_id,
  output logic       chg_valid,
  output logic       chg_coin,
  output logic       busy,
  output logic       fault
);
  localparam logic [5:0] MAX_C = 6'(MAX_CREDIT);

  state_t     state, state_nxt;
  logic [4:0] credit_q;
  logic [5:0] credit6, credit_nxt, coin_sum, price, chg_left;
  logic       coin_fits, rej_nxt, nack_nxt;
  logic [1:0] disp_id_nxt;
  logic       idle_clear, idle_expired, disp_expired;

  assign credit6   = {1'b0, credit_q};
  assign coin_sum  = credit6 + {1'b0, coin_value};
  assign coin_fits = coin_legal(coin_value) && (coin_sum <= MAX_C);
  assign chg_left  = credit6 - ((chg_coin == CHG_COIN_5) ? 6'd5 : 6'd1);
  assign credit    = credit_q;

  always_comb begin
    case (sel_id)
      2'd0:    price = 6'(PRICE0);
      2'd1:    price = 6'(PRICE1);
      2'd2:    price = 6'(PRICE2);
      default: price = 6'(PRICE3);
    endcase
  end

  // Any strobe counts as activity for the inactivity refund.
  assign idle_clear = (state != ST_COLLECT) || coin_valid || sel_valid || cancel;

  timeout_counter #(.LIMIT(IDLE_TIMEOUT)) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (idle_clear),
    .en      (state == ST_COLLECT),
    .expired (idle_expired)
  );

  timeout_counter #(.LIMIT(DISP_TIMEOUT)) u_disp_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_DISPENSE),
    .en      (state == ST_DISPENSE),
    .expired (disp_expired)
  );

  always_comb begin
    state_nxt   = state;
    credit_nxt  = credit6;
    disp_id_nxt = disp_id;
    rej_nxt     = 1'b0;
    nack_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coin_valid) begin
          if (coin_fits) begin
            credit_nxt = coin_sum;
            state_nxt  = ST_COLLECT;
          end else begin
            rej_nxt = 1'b1;
          end
        end
        nack_nxt = sel_valid;
      end
      ST_COLLECT: begin
        if (cancel) begin
          state_nxt = ST_CHANGE;
          rej_nxt   = coin_valid;
          nack_nxt  = sel_valid;
        end else if (coin_valid) begin
          if (coin_fits) credit_nxt = coin_sum;
          else           rej_nxt    = 1'b1;
          nack_nxt = sel_valid;
        end else if (sel_valid) begin
          if (credit6 >= price) begin
            credit_nxt  = credit6 - price;
            disp_id_nxt = sel_id;
            state_nxt   = ST_DISPENSE;
          end else begin
            nack_nxt = 1'b1;
          end
        end else if (idle_expired) begin
          state_nxt = ST_CHANGE;
        end
      end
      ST_DISPENSE: begin
        rej_nxt  = coin_valid;
        nack_nxt = sel_valid;
        if (disp_done)         state_nxt = (credit6 != 6'd0) ? ST_CHANGE : ST_IDLE;
        else if (disp_expired) state_nxt = ST_FAULT;
      end
      ST_CHANGE: begin
        rej_nxt  = coin_valid;
        nack_nxt = sel_valid;
        if (credit6 == 6'd0) begin
          state_nxt = ST_IDLE;
        end else if (chg_valid && chg_ready) begin
          credit_nxt = chg_left;
          if (chg_left == 6'd0) state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: begin
        rej_nxt  = coin_valid;
        nack_nxt = sel_valid;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      credit_q    <= '0;
      coin_reject <= 1'b0;
      sel_nack    <= 1'b0;
      disp_req    <= 1'b0;
      disp_id     <= '0;
      chg_valid   <= 1'b0;
      chg_coin    <= CHG_COIN_1;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit_q    <= credit_nxt[4:0];
      coin_reject <= rej_nxt;
      sel_nack    <= nack_nxt;
      disp_req    <= (state_nxt == ST_DISPENSE);
      disp_id     <= disp_id_nxt;
      chg_valid   <= (state_nxt == ST_CHANGE) && (credit_nxt != 6'd0);
      chg_coin    <= ((state_nxt == ST_CHANGE) && (credit_nxt >= 6'd5)) ? CHG_COIN_5 : CHG_COIN_1;
      busy        <= (state_nxt == ST_DISPENSE) || (state_nxt == ST_CHANGE) || (state_nxt == ST_FAULT);
      fault       <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: vector table, directed corner sequences, random stimulus vs reference model.
module tb_vend_controller;
  localparam int IDLE_T = 20;
  localparam int DISP_T = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [4:0] coin_value = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = '0;
  logic       cancel = 1'b0;
  logic       disp_done = 1'b0;
  logic       chg_ready = 1'b0;
  logic [4:0] credit;
  logic       coin_reject, sel_nack, disp_req;
  logic [1:0] disp_id;
  logic       chg_valid, chg_coin, busy, fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vend_controller #(.IDLE_TIMEOUT(IDLE_T), .DISP_TIMEOUT(DISP_T)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .disp_done(disp_done),
    .chg_ready(chg_ready), .credit(credit), .coin_reject(coin_reject), .sel_nack(sel_nack),
    .disp_req(disp_req), .disp_id(disp_id), .chg_valid(chg_valid), .chg_coin(chg_coin),
    .busy(busy), .fault(fault)
  );

  // Reference model: machine mode plus credit as plain integers.
  localparam int MD_IDLE = 0, MD_COLLECT = 1, MD_DISP = 2, MD_CHANGE = 3, MD_FAULT = 4;
  int m_mode = MD_IDLE, m_credit = 0, m_idle = 0, m_disp = 0, m_id = 0;
  bit m_rej = 0, m_nack = 0;
  int price [4] = '{20, 15, 10, 5};

  function automatic bit legal(input int v);
    return (v == 1) || (v == 5) || (v == 10);
  endfunction

  task automatic model_step();
    m_rej  = 0;
    m_nack = 0;
    if (reset) begin
      m_mode = MD_IDLE; m_credit = 0; m_id = 0; m_idle = 0; m_disp = 0;
      return;
    end
    case (m_mode)
      MD_IDLE: begin
        if (coin_valid) begin
          if (legal(int'(coin_value))) begin
            m_credit = m_credit + int'(coin_value);
            m_mode = MD_COLLECT;
            m_idle = 0;
          end else m_rej = 1;
        end
        m_nack = sel_valid;
      end
      MD_COLLECT: begin
        if (cancel) begin
          m_mode = MD_CHANGE; m_rej = coin_valid; m_nack = sel_valid;
        end else if (coin_valid) begin
          if (legal(int'(coin_value)) && m_credit + int'(coin_value) <= 29)
            m_credit = m_credit + int'(coin_value);
          else m_rej = 1;
          m_nack = sel_valid;
          m_idle = 0;
        end else if (sel_valid) begin
          if (m_credit >= price[sel_id]) begin
            m_credit = m_credit - price[sel_id];
            m_id = int'(sel_id);
            m_mode = MD_DISP;
            m_disp = 0;
          end else begin
            m_nack = 1;
            m_idle = 0;
          end
        end else begin
          m_idle++;
          if (m_idle == IDLE_T) m_mode = MD_CHANGE;
        end
      end
      MD_DISP: begin
        m_rej = coin_valid; m_nack = sel_valid;
        if (disp_done) m_mode = (m_credit > 0) ? MD_CHANGE : MD_IDLE;
        else begin
          m_disp++;
          if (m_disp == DISP_T) m_mode = MD_FAULT;
        end
      end
      MD_CHANGE: begin
        m_rej = coin_valid; m_nack = sel_valid;
        if (m_credit > 0 && chg_ready) m_credit = m_credit - ((m_credit >= 5) ? 5 : 1);
        if (m_credit == 0) m_mode = MD_IDLE;
      end
      default: begin
        m_rej = coin_valid; m_nack = sel_valid;
      end
    endcase
  endtask

  function automatic logic [13:0] obs();
    return {credit, coin_reject, sel_nack, disp_req, disp_id, chg_valid, chg_coin, busy, fault};
  endfunction

  function automatic logic [13:0] model_out();
    logic chgv;
    chgv = (m_mode == MD_CHANGE) && (m_credit > 0);
    return {5'(m_credit), m_rej, m_nack, m_mode == MD_DISP, 2'(m_id), chgv,
            chgv && (m_credit >= 5), m_mode >= MD_DISP, m_mode == MD_FAULT};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("model", int'(obs()), int'(model_out()));
  endtask

  task automatic drive(input logic cv, input logic [4:0] cval, input logic sv, input logic [1:0] sid,
                       input logic can, input logic dd, input logic cr);
    coin_valid = cv; coin_value = cval; sel_valid = sv; sel_id = sid;
    cancel = can; disp_done = dd; chg_ready = cr;
    cyc();
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; disp_done = 1'b0;
  endtask

  task automatic idle(input int n, input logic cr);
    repeat (n) drive(1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, cr);
  endtask

  task automatic coin(input logic [4:0] v);
    drive(1'b1, v, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1, 1'b0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic rst, cv; logic [4:0] cval; logic sv; logic [1:0] sid; logic can, dd, cr;
    logic [4:0] e_credit; logic e_rej, e_nack, e_req; logic [1:0] e_id; logic e_chgv, e_coin, e_busy;
  } vec_t;

  function automatic vec_t mk(input int rst, cv, cval, sv, sid, can, dd, cr,
                              input int ecr, rej, nack, req, id, chgv, ccoin, bsy);
    vec_t v;
    v.rst = 1'(rst); v.cv = 1'(cv); v.cval = 5'(cval); v.sv = 1'(sv); v.sid = 2'(sid);
    v.can = 1'(can); v.dd = 1'(dd); v.cr = 1'(cr);
    v.e_credit = 5'(ecr); v.e_rej = 1'(rej); v.e_nack = 1'(nack); v.e_req = 1'(req);
    v.e_id = 2'(id); v.e_chgv = 1'(chgv); v.e_coin = 1'(ccoin); v.e_busy = 1'(bsy);
    return v;
  endfunction

  vec_t vt [21];

  initial begin
    int n, sum;
    logic cv, sv, can;
    logic [4:0] cval;

    //           rst cv cval sv sid can dd cr | credit rej nack req id chgv coin busy
    vt[0]  = mk(1, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 10, 0, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 1, 10, 0, 0, 0, 0, 0,  20, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 1, 5,  0, 0, 0, 0, 0,  25, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 1, 5,  0, 0, 0, 0, 0,  25, 1, 0, 0, 0, 0, 0, 0);
    vt[5]  = mk(0, 1, 3,  0, 0, 0, 0, 0,  25, 1, 0, 0, 0, 0, 0, 0);
    vt[6]  = mk(1, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    vt[7]  = mk(0, 1, 1,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    vt[8]  = mk(0, 1, 1,  0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0);
    vt[9]  = mk(0, 1, 1,  0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0);
    vt[10] = mk(0, 1, 1,  0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0, 0);
    vt[11] = mk(0, 0, 0,  1, 3, 0, 0, 0,   4, 0, 1, 0, 0, 0, 0, 0);
    vt[12] = mk(0, 1, 1,  1, 3, 0, 0, 0,   5, 0, 1, 0, 0, 0, 0, 0);
    vt[13] = mk(0, 0, 0,  1, 3, 0, 0, 0,   0, 0, 0, 1, 3, 0, 0, 1);
    vt[14] = mk(0, 0, 0,  0, 0, 0, 1, 0,   0, 0, 0, 0, 3, 0, 0, 0);
    vt[15] = mk(0, 0, 0,  1, 1, 0, 0, 0,   0, 0, 1, 0, 3, 0, 0, 0);
    vt[16] = mk(0, 1, 10, 0, 0, 0, 0, 0,  10, 0, 0, 0, 3, 0, 0, 0);
    vt[17] = mk(0, 0, 0,  0, 0, 1, 0, 0,  10, 0, 0, 0, 3, 1, 1, 1);
    vt[18] = mk(0, 0, 0,  0, 0, 0, 0, 0,  10, 0, 0, 0, 3, 1, 1, 1);
    vt[19] = mk(0, 0, 0,  0, 0, 0, 0, 1,   5, 0, 0, 0, 3, 1, 1, 1);
    vt[20] = mk(0, 0, 0,  0, 0, 0, 0, 1,   0, 0, 0, 0, 3, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      reset = vt[i].rst;
      drive(vt[i].cv, vt[i].cval, vt[i].sv, vt[i].sid, vt[i].can, vt[i].dd, vt[i].cr);
      reset = 1'b0;
      check($sformatf("vec%0d", i),
            int'({credit, coin_reject, sel_nack, disp_req, disp_id, chg_valid, chg_coin, busy}),
            int'({vt[i].e_credit, vt[i].e_rej, vt[i].e_nack, vt[i].e_req, vt[i].e_id,
                  vt[i].e_chgv, vt[i].e_coin, vt[i].e_busy}));
    end

    // Exact purchase: disp_req held for the whole handshake, no change offered.
    do_reset();
    coin(5'd10); coin(5'd10);
    drive(1'b0, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    check("t1_credit", int'(credit), 0);
    check("t1_id", int'(disp_id), 0);
    n = int'(disp_req); sum = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b0);
      n += int'(disp_req); sum += int'(chg_valid);
    end
    drive(1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    sum += int'(chg_valid);
    check("t1_req_cycles", n, 5);
    check("t1_no_change", sum, 0);
    check("t1_idle", int'({busy, disp_req}), 0);

    // Purchase with change, hopper always ready.
    do_reset();
    coin(5'd10); coin(5'd10); coin(5'd5); coin(5'd1);
    check("t2_credit", int'(credit), 26);
    drive(1'b0, 5'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    check("t2_after_sel", int'(credit), 16);
    idle(2, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    n = 0; sum = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      if (chg_valid) begin n++; sum += chg_coin ? 5 : 1; end
      idle(1, 1'b1);
    end
    check("t2_coins", n, 4);
    check("t2_sum", sum, 16);
    check("t2_end", int'({busy, credit}), 0);

    // Inactivity refund with a hopper that is ready every other cycle.
    do_reset();
    coin(5'd5); coin(5'd1); coin(5'd1);
    idle(IDLE_T - 1, 1'b0);
    check("t5_before_timeout", int'(busy), 0);
    idle(1, 1'b0);
    check("t5_refund", int'({chg_valid, chg_coin, credit}), int'({1'b1, 1'b1, 5'd7}));
    n = 0; sum = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      if (chg_valid && i[0]) begin n++; sum += chg_coin ? 5 : 1; end
      idle(1, 1'(i[0]));
    end
    check("t5_xfers", n, 3);
    check("t5_sum", sum, 7);

    // Dispense timeout into FAULT, then reset from the middle of CHANGE.
    do_reset();
    coin(5'd10); coin(5'd10);
    drive(1'b0, 5'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    idle(DISP_T - 1, 1'b0);
    check("t6_pre_fault", int'({fault, disp_req}), 1);
    idle(1, 1'b0);
    check("t6_fault", int'({fault, disp_req, busy, credit}), int'({1'b1, 1'b0, 1'b1, 5'd10}));
    coin(5'd5);
    check("t6_fault_reject", int'({coin_reject, credit}), int'({1'b1, 5'd10}));
    do_reset();
    coin(5'd10);
    drive(1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    check("t6_mid_change", int'({chg_valid, credit}), int'({1'b1, 5'd5}));
    do_reset();
    check("t6_reset", int'(obs()), 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      cv = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: cval = 5'd1;
        1: cval = 5'd5;
        2: cval = 5'd10;
        default: cval = 5'($urandom_range(0, 31));
      endcase
      sv  = ($urandom_range(0, 4) == 0);
      can = !cv && !sv && ($urandom_range(0, 11) == 0);
      drive(cv, cval, sv, 2'($urandom_range(0, 3)), can,
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
